layer_serializer: RTL and testbench

LAYER_SERIALIZER -- requirements
Module: layer_serializer

---
 rtl/layer_serializer.sv | 132 +++++++++++++
 tb/tb_layer_serializer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_serializer.sv
// Layer output serializer: captures a full layer vector and streams it one element per cycle.
// Optional one-entry skid buffer enabled by defining LAYER_SER_SKID_EN.
module layer_serializer #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    x_valid,
  output logic [dataWidth-1:0]    x_out,
  output logic                    x_last,
  output logic                    busy,
  output logic                    overflow
);

  localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [IDX_W-1:0]     idx_inc;
  logic [dataWidth-1:0] in_elem [NN];
  logic [dataWidth-1:0] buf_reg [NN];
  logic                 x_valid_reg;
  logic [dataWidth-1:0] x_out_reg;
  logic                 x_last_reg;
  logic                 busy_reg;
  logic                 overflow_reg;
  logic                 capture;

`ifdef LAYER_SER_SKID_EN
  logic [dataWidth-1:0] skid_reg [NN];
  logic                 skid_full_reg;
`endif

  generate
    for (genvar gi = 0; gi < NN; gi++) begin : g_unpack
      assign in_elem[gi] = i_data[gi*dataWidth +: dataWidth];
    end
  endgenerate

  assign capture = &i_valid;
  assign idx_inc = idx_reg + IDX_W'(1);

  // idx_reg is the index of the element currently shown on x_out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      x_valid_reg  <= 1'b0;
      x_out_reg    <= '0;
      x_last_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      for (int k = 0; k < NN; k++) buf_reg[k] <= '0;
`ifdef LAYER_SER_SKID_EN
      for (int k = 0; k < NN; k++) skid_reg[k] <= '0;
      skid_full_reg <= 1'b0;
`endif
    end else begin
      overflow_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (capture) begin
            buf_reg     <= in_elem;
            x_out_reg   <= in_elem[0];
            x_valid_reg <= 1'b1;
            x_last_reg  <= (NN == 1);
            idx_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          if (idx_reg == LAST_IDX) begin
`ifdef LAYER_SER_SKID_EN
            // A parked vector goes first; a new capture refills the skid slot.
            if (skid_full_reg) begin
              buf_reg    <= skid_reg;
              x_out_reg  <= skid_reg[0];
              x_last_reg <= (NN == 1);
              idx_reg    <= '0;
              if (capture) skid_reg <= in_elem;
              else         skid_full_reg <= 1'b0;
            end else
`endif
            if (capture) begin
              buf_reg    <= in_elem;
              x_out_reg  <= in_elem[0];
              x_last_reg <= (NN == 1);
              idx_reg    <= '0;
            end else begin
              x_valid_reg <= 1'b0;
              x_last_reg  <= 1'b0;
              busy_reg    <= 1'b0;
              idx_reg     <= '0;
              state_reg   <= IDLE;
            end
          end else begin
            x_out_reg  <= buf_reg[idx_inc];
            x_last_reg <= (idx_inc == LAST_IDX);
            idx_reg    <= idx_inc;
            if (capture) begin
`ifdef LAYER_SER_SKID_EN
              if (skid_full_reg) begin
                overflow_reg <= 1'b1;
              end else begin
                skid_reg      <= in_elem;
                skid_full_reg <= 1'b1;
              end
`else
              overflow_reg <= 1'b1;
`endif
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign x_valid  = x_valid_reg;
  assign x_out    = x_out_reg;
  assign x_last   = x_last_reg;
  assign busy     = busy_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: scheduled captures checked cycle by cycle against a
// timeline model of when each accepted vector is streamed out.
module tb_layer_serializer;
  localparam int NN    = 10;
  localparam int DW    = 16;
  localparam int NCYC  = 75;
  localparam int MAXV  = 8;
`ifdef LAYER_SER_SKID_EN
  localparam int DEPTH = 1;
`else
  localparam int DEPTH = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NN-1:0]     i_valid = '0;
  logic [NN*DW-1:0]  i_data = '0;
  logic              x_valid;
  logic [DW-1:0]     x_out;
  logic              x_last;
  logic              busy;
  logic              overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // scenario description filled by each test
  int          cap_list [MAXV];
  int          ncap;
  int          rcyc;
  logic [DW-1:0] vdat [MAXV][NN];

  // expected per-cycle outputs
  logic          exp_valid [NCYC];
  logic [DW-1:0] exp_out   [NCYC];
  logic          exp_last  [NCYC];
  logic          exp_ovf   [NCYC];

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .x_valid(x_valid), .x_out(x_out), .x_last(x_last),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    i_valid = '1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    i_valid = '0;
  endtask

  function automatic logic [NN-1:0] partial_valid();
    logic [NN-1:0] pv;
    pv = '1;
    pv[$urandom_range(0, NN-1)] = 1'b0;
    if ($urandom_range(0, 1) == 1) pv = pv & NN'($urandom);
    return pv;
  endfunction

  // Timeline model: a capture starts streaming right after it is sampled if the
  // output is free then, otherwise it waits (if a wait slot exists) until the
  // previous vector ends; with no slot it is dropped and overflow pulses.
  task automatic build_model();
    int  emit_end, start, waiting, c;
    int  vs [MAXV];
    bit  acc [MAXV];
    bit  post [MAXV];
    bit  cleared;
    logic [DW-1:0] hold;
    emit_end = -100;
    cleared  = 0;
    for (int t = 0; t < NCYC; t++) exp_ovf[t] = 1'b0;
    for (int i = 0; i < ncap; i++) begin
      c = cap_list[i];
      acc[i]  = 0;
      vs[i]   = 0;
      post[i] = (rcyc >= 0 && c > rcyc);
      if (rcyc >= 0 && c >= rcyc && !cleared) begin
        cleared  = 1;
        emit_end = -100;
      end
      if (c == rcyc) continue;
      start = (c + 1 > emit_end + 1) ? c + 1 : emit_end + 1;
      waiting = 0;
      for (int j = 0; j < i; j++)
        if (acc[j] && post[j] == post[i] && vs[j] > c + 1) waiting++;
      if (start == c + 1 || waiting < DEPTH) begin
        acc[i]   = 1;
        vs[i]    = start;
        emit_end = start + NN - 1;
      end else if (c + 1 < NCYC) begin
        exp_ovf[c + 1] = 1'b1;
      end
    end
    hold = '0;
    for (int t = 0; t < NCYC; t++) begin
      exp_valid[t] = 1'b0;
      exp_last[t]  = 1'b0;
      if (rcyc >= 0 && t == rcyc + 1) hold = '0;
      for (int i = 0; i < ncap; i++) begin
        if (acc[i] && t >= vs[i] && t < vs[i] + NN &&
            !(!post[i] && rcyc >= 0 && t > rcyc)) begin
          exp_valid[t] = 1'b1;
          hold         = vdat[i][t - vs[i]];
          exp_last[t]  = (t == vs[i] + NN - 1);
        end
      end
      exp_out[t] = hold;
    end
  endtask

  task automatic run_scenario(input string name);
    int vi;
    build_model();
    do_reset();
    for (int c = 0; c < NCYC; c++) begin
      n_tests += 5;
      if (x_valid !== exp_valid[c]) begin
        n_fail++;
        $display("FAIL %s x_valid cyc=%0d got %b expected %b", name, c, x_valid, exp_valid[c]);
      end
      if (x_out !== exp_out[c]) begin
        n_fail++;
        $display("FAIL %s x_out cyc=%0d got %h expected %h", name, c, x_out, exp_out[c]);
      end
      if (x_last !== exp_last[c]) begin
        n_fail++;
        $display("FAIL %s x_last cyc=%0d got %b expected %b", name, c, x_last, exp_last[c]);
      end
      if (busy !== exp_valid[c]) begin
        n_fail++;
        $display("FAIL %s busy cyc=%0d got %b expected %b", name, c, busy, exp_valid[c]);
      end
      if (overflow !== exp_ovf[c]) begin
        n_fail++;
        $display("FAIL %s overflow cyc=%0d got %b expected %b", name, c, overflow, exp_ovf[c]);
      end
      rst = (c == rcyc) ? 1'b0 : 1'b1;
      vi = -1;
      for (int i = 0; i < ncap; i++) if (cap_list[i] == c) vi = i;
      if (vi >= 0) begin
        i_valid = '1;
        for (int k = 0; k < NN; k++) i_data[k*DW +: DW] = vdat[vi][k];
      end else begin
        i_valid = ($urandom_range(0, 2) == 0) ? partial_valid() : '0;
        for (int k = 0; k < NN; k++) i_data[k*DW +: DW] = DW'($urandom);
      end
      @(negedge clk);
    end
    i_valid = '0;
    $display("[TB] scenario %s: %0d captures, reset cycle %0d", name, ncap, rcyc);
  endtask

  task automatic fill_directed();
    for (int v = 0; v < MAXV; v++)
      for (int k = 0; k < NN; k++) vdat[v][k] = DW'(16'h0100 * (v + 1) + k);
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      n_tests += 5;
      if (x_valid !== 1'b0 || x_out !== '0 || x_last !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got v=%b o=%h l=%b b=%b ov=%b expected all zero",
                 c, x_valid, x_out, x_last, busy, overflow);
      end
      @(negedge clk);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_partial_valid();
    do_reset();
    i_valid = '1;
    i_valid[4] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int k = 0; k < NN; k++) i_data[k*DW +: DW] = DW'(16'h0100 + k);
      @(negedge clk);
      n_tests += 2;
      if (x_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL partial x_valid cyc=%0d got %b expected 0", c, x_valid);
      end
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL partial busy cyc=%0d got %b expected 0", c, busy);
      end
    end
    i_valid = '0;
    $display("[TB] test_partial_valid done");
  endtask

  task automatic test_single();
    fill_directed(); ncap = 1; cap_list[0] = 5; rcyc = -1;
    run_scenario("single");
  endtask

  task automatic test_back_to_back();
    fill_directed(); ncap = 2; cap_list[0] = 5; cap_list[1] = 15; rcyc = -1;
    run_scenario("back_to_back");
  endtask

  task automatic test_mid_capture();
    fill_directed(); ncap = 2; cap_list[0] = 5; cap_list[1] = 8; rcyc = -1;
    run_scenario("mid_capture");
  endtask

  task automatic test_triple();
    fill_directed(); ncap = 3; cap_list[0] = 5; cap_list[1] = 8; cap_list[2] = 9; rcyc = -1;
    run_scenario("triple");
  endtask

  task automatic test_mid_reset();
    fill_directed(); ncap = 2; cap_list[0] = 5; cap_list[1] = 14; rcyc = 10;
    run_scenario("mid_reset");
  endtask

  task automatic test_random();
    int prev;
    for (int it = 0; it < 12; it++) begin
      ncap = $urandom_range(1, 4);
      prev = 0;
      for (int i = 0; i < ncap; i++) begin
        prev = prev + $urandom_range(1, 12);
        cap_list[i] = prev;
        for (int k = 0; k < NN; k++) vdat[i][k] = DW'($urandom);
      end
      rcyc = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 40) : -1;
      run_scenario("random");
    end
  endtask

  initial begin
    test_reset();
    test_partial_valid();
    test_single();
    test_back_to_back();
    test_mid_capture();
    test_triple();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
